uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            PRESCALE,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned PS_W  = 6;
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e                state_q;
    logic                  tx_q;
    logic                  busy_q;
    logic [PS_W-1:0]       cnt_q;
    logic [PS_W-1:0]       n_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  bit_done;
    logic [IDX_W-1:0]      idx_d;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
    logic par_bit;

    assign par_bit = (^data_q) ^ par_typ_q;
`else
    logic unused_par;

    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    // Last cycle of the current bit period; n_q is never 0 outside IDLE.
    assign bit_done = (cnt_q == (n_q - PS_W'(1)));
    assign idx_d    = idx_q + IDX_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            data_q    <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    idx_q  <= '0;
                    if (DATA_VALID) begin
                        data_q    <= P_DATA;
                        n_q       <= (PRESCALE == '0) ? PS_W'(1) : PRESCALE;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
`endif
                        state_q   <= START;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= data_q[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + PS_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                tx_q    <= par_bit;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            idx_q <= idx_d;
                            tx_q  <= data_q[idx_d];
                        end
                    end else begin
                        cnt_q <= cnt_q + PS_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + PS_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + PS_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a per-cycle frame model checked every cycle, plus literal frame expectations.
module tb_uart_tx;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] p_data = '0;
    logic         dv = 1'b0;
    logic         par_en = 1'b0;
    logic         par_typ = 1'b0;
    logic [5:0]   prescale = 6'd1;
    logic         tx_out;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx #(.DATA_WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .DATA_VALID(dv),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .PRESCALE(prescale),
        .TX_OUT(tx_out), .Busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Model: a frame is a list of line levels, one per clock cycle of Busy=1.
    logic q[$];
    logic m_tx   = 1'b1;
    logic m_busy = 1'b0;

    task automatic build_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                               input logic [5:0] ps);
        logic bits[$];
        int   n;
        n = (ps == 0) ? 1 : int'(ps);
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        if (pe) bits.push_back((^d) ^ pt);
`else
        if (pe || pt) begin end
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) for (int k = 0; k < n; k++) q.push_back(bits[i]);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end else if (q.size() > 0) begin
                m_tx   = q.pop_front();
                m_busy = 1'b1;
            end else if (!m_busy && dv) begin
                build_frame(p_data, par_en, par_typ, prescale);
                m_tx   = q.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_tx", 32'(tx_out), 32'(m_tx));
            check("model_busy", 32'(busy), 32'(m_busy));
        end
    end

    // One DATA_VALID pulse, inputs scrambled after acceptance, then literal frame check.
    task automatic run_frame(input string name, input logic [W-1:0] d, input logic pe,
                             input logic pt, input logic [5:0] ps,
                             input logic [15:0] exp_bits, input int exp_nbits, input int n);
        logic samples[0:299];
        logic [15:0] got_bits;
        int cycles;
        @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; prescale = ps; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        p_data = ~d; par_en = ~pe; par_typ = ~pt; prescale = ps + 6'd3;
        cycles = 0;
        while (busy && cycles < 300) begin
            samples[cycles] = tx_out;
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 300) check({name, "_timeout"}, 32'(cycles), 32'(exp_nbits * n));
        check({name, "_len"}, 32'(cycles), 32'(exp_nbits * n));
        got_bits = '0;
        for (int i = 0; i < exp_nbits; i++)
            if (i * n < cycles) got_bits[i] = samples[i * n];
        check({name, "_bits"}, 32'(got_bits), 32'(exp_bits));
        check({name, "_idle_tx"}, 32'(tx_out), 32'd1);
    endtask

    initial begin
        int t;
        int gap;
        logic gap_tx_ok;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_tx", 32'(tx_out), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        run_frame("a5_even_p1", 8'hA5, 1'b1, 1'b0, 6'd1, 16'b10101001010, 11, 1);
        run_frame("a5_odd_p8", 8'hA5, 1'b1, 1'b1, 6'd8, 16'b11101001010, 11, 8);
`else
        run_frame("a5_even_p1", 8'hA5, 1'b1, 1'b0, 6'd1, 16'b1101001010, 10, 1);
        run_frame("a5_odd_p8", 8'hA5, 1'b1, 1'b1, 6'd8, 16'b1101001010, 10, 8);
`endif
        run_frame("3c_nopar_p4", 8'h3C, 1'b0, 1'b0, 6'd4, 16'b1001111000, 10, 4);
        run_frame("3c_p0", 8'h3C, 1'b0, 1'b1, 6'd0, 16'b1001111000, 10, 1);

        // DATA_VALID held high: back-to-back frames with P_DATA changing mid-frame.
        @(negedge clk);
        p_data = 8'h11; par_en = 1'b0; prescale = 6'd2; dv = 1'b1;
        @(negedge clk);
        p_data = 8'h22;
        t = 0;
        while (busy && t < 200) begin @(negedge clk); t++; end
        gap = 0; gap_tx_ok = 1'b1;
        while (!busy && gap < 10) begin
            if (tx_out !== 1'b1) gap_tx_ok = 1'b0;
            gap++;
            @(negedge clk);
        end
        check("b2b_gap", 32'(gap), 32'd1);
        check("b2b_gap_tx", 32'(gap_tx_ok), 32'd1);
        p_data = 8'h5A;
        t = 0;
        while (busy && t < 200) begin @(negedge clk); t++; end
        dv = 1'b0;
        t = 0;
        while (busy && t < 200) begin @(negedge clk); t++; end
        check("b2b_done", 32'(busy), 32'd0);

        // Reset during the 4th data bit, then a clean frame.
        @(negedge clk);
        p_data = 8'hA5; par_en = 1'b0; prescale = 6'd3; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", 32'(tx_out), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        run_frame("post_rst_3c", 8'h3C, 1'b0, 1'b0, 6'd4, 16'b1001111000, 10, 4);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
